// File: rtl/fifo_uart_tx_if.sv
// FIFO-side handshake of the UART transmitter: head word, empty flag, enable and pop strobe.
interface fifo_uart_tx_if #(parameter int DBIT = 8);
  logic            tx_en;
  logic            empty;
  logic [DBIT-1:0] r_data;
  logic            rd;

  modport master (output tx_en, empty, r_data, input rd);
  modport slave  (input tx_en, empty, r_data, output rd);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO, sending frames back-to-back
// (start, DBIT data bits LSB first, SB_TICK-tick stop) while tx_en is high and words remain.
module fifo_uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163
) (
  input  logic          clk,
  input  logic          reset,
  fifo_uart_tx_if.slave fifo,
  output logic          tx,
  output logic          tx_busy,
  output logic          tx_done_tick
);

  localparam int DW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d, b_shift;
  logic            tx_q, tx_d;
  logic            tick, pop_ok, rd_c, done_c;

  assign tick    = (div_q == DW'(DVSR - 1));
  // Reset gates the pop so no word is consumed on a reset edge.
  assign pop_ok  = fifo.tx_en & ~fifo.empty & ~reset;
  assign b_shift = b_q >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_d    = tx_q;
    rd_c    = 1'b0;
    done_c  = 1'b0;
    if (state_q != IDLE) div_d = tick ? '0 : div_q + 1'b1;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop_ok) begin
          rd_c    = 1'b1;
          b_d     = fifo.r_data;
          state_d = START;
          tx_d    = 1'b0;
          div_d   = '0;
          s_d     = '0;
        end
      end
      START: if (tick) begin
        if (s_q == SW'(15)) begin
          s_d     = '0;
          n_d     = '0;
          state_d = DATA;
          tx_d    = b_q[0];
        end else s_d = s_q + 1'b1;
      end
      DATA: if (tick) begin
        if (s_q == SW'(15)) begin
          s_d = '0;
          b_d = b_shift;
          if (n_q == NW'(DBIT - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            n_d  = n_q + 1'b1;
            tx_d = b_shift[0];
          end
        end else s_d = s_q + 1'b1;
      end
      STOP: if (tick) begin
        if (s_q == SW'(SB_TICK - 1)) begin
          done_c = 1'b1;
          // A waiting word starts its start bit on the very next edge: no idle gap.
          if (pop_ok) begin
            rd_c    = 1'b1;
            b_d     = fifo.r_data;
            state_d = START;
            tx_d    = 1'b0;
            div_d   = '0;
            s_d     = '0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else s_d = s_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo.rd      = rd_c;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_c & ~reset;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx at DVSR=2: FIFO model + scoreboard of expected words checked
// cycle-by-cycle against the serial waveform; a second SB_TICK=24 instance checks the long stop.
module tb_fifo_uart_tx;
  localparam int DBIT = 8, DVSR = 2, BIT = 16 * DVSR, FRAME = (16 * (DBIT + 1) + 16) * DVSR;

  logic clk = 0, reset = 1;
  logic tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  int   cyc = 0, n_vec = 0, n_err = 0;

  fifo_uart_tx_if #(.DBIT(DBIT)) ua ();
  fifo_uart_tx_if #(.DBIT(DBIT)) ub ();

  fifo_uart_tx #(.DBIT(DBIT), .SB_TICK(16), .DVSR(DVSR)) dut_a (
    .clk(clk), .reset(reset), .fifo(ua), .tx(tx_a), .tx_busy(busy_a), .tx_done_tick(done_a));
  fifo_uart_tx #(.DBIT(DBIT), .SB_TICK(24), .DVSR(DVSR)) dut_b (
    .clk(clk), .reset(reset), .fifo(ub), .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic level(input logic [7:0] d, input int o);
    int k;
    k = (o - 1) / BIT;
    if (k == 0) return 1'b0;
    if (k <= DBIT) return d[k-1];
    return 1'b1;
  endfunction

  // FIFO model: pop on the edge that ends a cycle with rd high
  logic [7:0] fq[$];
  logic       pend_pop = 0;
  always @(posedge clk) begin
    #1;
    if (pend_pop && fq.size() != 0) void'(fq.pop_front());
    ua.empty  = (fq.size() == 0);
    ua.r_data = (fq.size() != 0) ? fq[0] : 8'h00;
  end

  // Scoreboard monitor for instance a
  logic [7:0] exp_q[$];
  logic       hist[0:511];
  logic       open = 0, live = 0;
  int         off = 0, nrd = 0, ndone = 0, last_rd = 0, rd_gap = 0, idle_bad = 0;
  always @(negedge clk) begin
    logic [7:0] e;
    int bad;
    pend_pop = ua.rd;
    if (reset) begin
      open = 0;
      live = 1;
    end else if (live) begin
      if (!busy_a && tx_a !== 1'b1) idle_bad++;
      if (open) begin
        off++;
        if (off < 512) hist[off] = tx_a;
      end
      if (done_a) begin
        check("done_in_frame", open, 1);
        if (open) begin
          check("exp_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_len", off, FRAME);
            bad = 0;
            for (int o = 1; o <= FRAME; o++) if (hist[o] !== level(e, o)) bad++;
            check("frame_bits", bad, 0);
          end
          ndone++;
          open = 0;
        end
      end
      if (ua.rd) begin
        nrd++;
        check("rd_nonempty", ua.empty, 0);
        check("rd_single", open, 0);
        if (nrd > 1) rd_gap = cyc - last_rd;
        last_rd = cyc;
        open    = 1;
        off     = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(!busy_a && !ua.rd && (fq.size() == 0 || !ua.tx_en)) && n < lim);
    check("idle_reached", n < lim, 1);
  endtask

  task automatic wait_rd(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ua.rd && n < lim);
    check("rd_seen", ua.rd, 1);
  endtask

  initial begin
    int r0, d0, rdc, txl, bz, t0, run, len;
    logic [7:0] byte_b;
    ua.tx_en = 0; ub.tx_en = 0; ub.empty = 1; ub.r_data = 8'h00;
    repeat (3) step();
    reset = 0;
    // reset state
    @(negedge clk);
    check("rst_tx", tx_a, 1); check("rst_busy", busy_a, 0);
    check("rst_rd", ua.rd, 0); check("rst_done", done_a, 0);
    // rd stays low under reset even with data waiting
    step(); reset = 1; ua.tx_en = 1; fq.push_back(8'h81); exp_q.push_back(8'h81);
    repeat (2) begin @(negedge clk); check("rd_in_reset", ua.rd, 0); end
    check("fifo_kept", fq.size(), 1);
    step(); reset = 0;
    wait_idle(1000);
    // empty FIFO for 1000 cycles
    rdc = 0; txl = 0; bz = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ua.rd) rdc++;
      if (tx_a !== 1'b1) txl++;
      if (busy_a) bz++;
    end
    check("empty_rd", rdc, 0); check("empty_tx_low", txl, 0); check("empty_busy", bz, 0);
    // single word
    r0 = nrd; d0 = ndone;
    step(); fq.push_back(8'hA5); exp_q.push_back(8'hA5);
    wait_idle(1000);
    check("a5_rd", nrd - r0, 1); check("a5_done", ndone - d0, 1); check("a5_tx_idle", tx_a, 1);
    // back-to-back
    r0 = nrd; d0 = ndone;
    step(); fq.push_back(8'h00); fq.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    wait_idle(2000);
    check("b2b_rd", nrd - r0, 2); check("b2b_gap", rd_gap, FRAME); check("b2b_done", ndone - d0, 2);
    // tx_en dropped mid-frame
    r0 = nrd;
    step(); fq.push_back(8'h11); fq.push_back(8'h22); exp_q.push_back(8'h11);
    wait_rd(10);
    repeat (99) @(negedge clk);
    step(); ua.tx_en = 0;
    wait_idle(1000);
    repeat (20) @(negedge clk);
    check("en_rd", nrd - r0, 1); check("en_left", fq.size(), 1);
    check("en_tx", tx_a, 1); check("en_busy", busy_a, 0);
    exp_q.push_back(8'h22);
    step(); ua.tx_en = 1;
    wait_idle(1000);
    // reset during data bit 3
    step(); fq.push_back(8'h5A);
    wait_rd(10);
    fq.push_back(8'h6B);
    repeat (140) @(negedge clk);
    step(); reset = 1; ua.tx_en = 0;
    @(negedge clk); check("mid_rst_rd", ua.rd, 0);
    step(); reset = 0;
    @(negedge clk);
    check("post_rst_tx", tx_a, 1); check("post_rst_busy", busy_a, 0); check("post_rst_rd", ua.rd, 0);
    exp_q.push_back(8'h6B); r0 = nrd;
    step(); ua.tx_en = 1;
    wait_idle(1000);
    check("post_rst_frame", nrd - r0, 1); check("exp_drained", exp_q.size(), 0);
    check("idle_tx_high", idle_bad, 0);
    // SB_TICK=24 instance, word 0x3C
    step(); ub.r_data = 8'h3C; ub.empty = 0; ub.tx_en = 1;
    len = 0;
    do begin @(negedge clk); len++; end while (!ub.rd && len < 10);
    check("b_rd", ub.rd, 1);
    t0 = cyc; step(); ub.empty = 1;
    byte_b = 8'h00; run = 0; len = 0;
    do begin
      @(negedge clk);
      len = cyc - t0;
      run = (tx_b === 1'b1) ? run + 1 : 0;
      for (int k = 0; k < DBIT; k++) if (len == BIT * (k + 1) + 16) byte_b[k] = tx_b;
    end while (!done_b && len < 400);
    check("b_len", len, (16 * (DBIT + 1) + 24) * DVSR);
    check("b_stop_high", run, 24 * DVSR);
    check("b_byte", byte_b, 8'h3C);
    repeat (5) @(negedge clk);
    check("b_idle", busy_b, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter DBIT, default 8, data word width and data bits per frame.
REQ-002 Parameter SB_TICK, default 16, stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 Parameter DVSR, default 163, clk cycles per oversample tick (16 ticks per bit); legal range DVSR >= 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_en  input  1  permits popping a new word when high.
REQ-007 empty  input  1  FIFO empty flag from the buffer being drained.
REQ-008 r_data  input  DBIT  FIFO head word, valid whenever empty=0 (first-word fall-through).
REQ-009 rd  output  1  FIFO pop strobe, one clk cycle per word.
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 tx_busy  output  1  high whenever a frame is in progress.
REQ-012 tx_done_tick  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; tx_busy = (state != IDLE).
REQ-014 Pop condition = tx_en & ~empty, evaluated in IDLE and in the last cycle of STOP.
REQ-015 When the pop condition holds, rd SHALL be 1 for exactly that cycle, the shift register SHALL load r_data on that edge, and the FSM SHALL go to START.
REQ-016 rd SHALL never be 1 while empty=1, and never more than once per frame.
REQ-017 The divisor counter SHALL be 0 on entry to START and count 0..DVSR-1; a tick occurs when it equals DVSR-1.
REQ-018 The tick counter SHALL count ticks 0..15 per bit (0..SB_TICK-1 in STOP) and clear at each bit boundary.
REQ-019 tx SHALL go low on the edge that enters START and stay low for 16*DVSR cycles.
REQ-020 DATA SHALL transmit DBIT bits LSB first, each for 16*DVSR cycles, shifting right at each bit boundary; a 3-bit-wide-enough bit counter tracks 0..DBIT-1.
REQ-021 STOP SHALL drive tx=1 for SB_TICK*DVSR cycles.
REQ-022 tx_done_tick SHALL be 1 in the last cycle of STOP only.
REQ-023 At the end of STOP, if the pop condition holds, the next frame's start bit SHALL begin on the following edge (no idle gap); otherwise FSM SHALL enter IDLE with tx=1.
REQ-024 Total frame length SHALL be (16*(DBIT+1) + SB_TICK)*DVSR cycles.
REQ-025 tx_en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-026 Changes on empty or r_data after the pop SHALL NOT affect the frame in progress.

Reset
REQ-027 While reset=1 at a rising edge: state IDLE, all counters 0, shift register 0; next cycle tx=1, rd=0, tx_busy=0, tx_done_tick=0.
REQ-028 rd SHALL be 0 in any cycle where reset=1, regardless of empty.
REQ-029 Reset mid-frame SHALL abandon the frame (the popped word is lost); tx returns high on the reset edge.

Verification (DBIT=8, SB_TICK=16, DVSR=2; bit = 32 cycles, frame = 320 cycles)
REQ-030 Single word: tx_en=1, FIFO holds 0xA5 -> one rd pulse; tx low 32 cycles, then 1,0,1,0,0,1,0,1 each 32 cycles, high 32 cycles; tx_done_tick pulse at cycle 320; return to IDLE.
REQ-031 Back-to-back: FIFO holds 0x00, 0xFF -> rd pulses exactly 320 cycles apart; second start bit follows stop with no extra high cycle; two done pulses.
REQ-032 Empty: empty=1 for 1000 cycles -> rd never 1, tx=1, tx_busy=0 throughout.
REQ-033 tx_en dropped at cycle 100 of a frame with FIFO non-empty -> frame completes at cycle 320; no further rd; IDLE with tx=1.
REQ-034 Reset asserted for one cycle during data bit 3 -> tx=1, tx_busy=0, rd=0 after that edge; after release with empty=0, fresh rd pulse and full new frame.
REQ-035 SB_TICK=24 build, word 0x3C -> stop bit high 48 cycles; frame 336 cycles.
